// File: rtl/icap_pkg.sv
// Shared types and helpers for the ICAP configuration loader.
package icap_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHunt,
    StSync1,
    StSync2,
    StLoad,
    StDone,
    StFail
  } state_e;

  localparam logic [31:0] SyncWordDefault = 32'hAA995566;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_sync_hunter.sv
// Sync-word hunter: match shifter, scanned-byte counter, match/timeout pulses.
module icap_sync_hunter
  import icap_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD  = SyncWordDefault,
  parameter int unsigned HUNT_LIMIT = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       hunt_i,
  input  logic       byte_stb_i,
  input  logic [7:0] byte_i,
  output logic       match_o,
  output logic       timeout_o
);

  localparam int unsigned CntW = $clog2(HUNT_LIMIT + 1);

  logic [31:0]     shift_q, shift_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     shift_next;
  logic [CntW-1:0] cnt_next;
  logic            step;

  always_comb begin
    step       = hunt_i & byte_stb_i;
    shift_next = {shift_q[23:0], byte_i};
    cnt_next   = cnt_q + CntW'(1);
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (step) begin
      shift_d = shift_next;
      cnt_d   = cnt_next;
    end
    // A match on the limit byte wins over the timeout.
    match_o   = step && (shift_next == SYNC_WORD);
    timeout_o = step && !match_o && (cnt_next == CntW'(HUNT_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/icap_loader.sv
// Byte-stream to ICAP loader: hunts for sync, replays it, then packs byte pairs into writes.
module icap_loader
  import icap_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD  = SyncWordDefault,
  parameter int unsigned LEN_WORDS  = 1024,
  parameter int unsigned HUNT_LIMIT = 65536,
  parameter bit          BIT_SWAP   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_stb,
  input  logic [7:0]  byte_in,
  output logic        icap_ce_n,
  output logic        icap_we_n,
  output logic [15:0] icap_din,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned WordW = $clog2(LEN_WORDS + 1);

  state_e           state_q, state_d;
  logic [WordW-1:0] word_cnt_q, word_cnt_d;
  logic             phase_q, phase_d;
  logic [7:0]       hi_q, hi_d;
  logic             ce_n_q, ce_n_d;
  logic             we_n_q, we_n_d;
  logic [15:0]      din_q, din_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             hunt_clear, hunt_match, hunt_timeout;

  function automatic logic [15:0] fmt(input logic [15:0] w);
    return BIT_SWAP ? {bitrev8(w[15:8]), bitrev8(w[7:0])} : w;
  endfunction

  icap_sync_hunter #(
    .SYNC_WORD (SYNC_WORD),
    .HUNT_LIMIT(HUNT_LIMIT)
  ) u_hunter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (hunt_clear),
    .hunt_i    (state_q == StHunt),
    .byte_stb_i(byte_stb),
    .byte_i    (byte_in),
    .match_o   (hunt_match),
    .timeout_o (hunt_timeout)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    ce_n_d     = 1'b1;
    din_d      = din_q;
    done_d     = done_q;
    error_d    = error_q;
    hunt_clear = 1'b0;

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          state_d    = StHunt;
          word_cnt_d = '0;
          phase_d    = 1'b0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          hunt_clear = 1'b1;
        end
      end
      StHunt: begin
        if (hunt_match) begin
          state_d = StSync1;
        end else if (hunt_timeout) begin
          state_d = StFail;
          error_d = 1'b1;
        end
      end
      StSync1: begin
        ce_n_d  = 1'b0;
        din_d   = fmt(SYNC_WORD[31:16]);
        state_d = StSync2;
      end
      StSync2: begin
        ce_n_d  = 1'b0;
        din_d   = fmt(SYNC_WORD[15:0]);
        phase_d = 1'b0;
        state_d = StLoad;
      end
      StLoad: begin
        // Completion is judged on the registered count, one cycle after the last write.
        if (word_cnt_q == WordW'(LEN_WORDS)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (byte_stb) begin
          if (!phase_q) begin
            hi_d    = byte_in;
            phase_d = 1'b1;
          end else begin
            ce_n_d     = 1'b0;
            din_d      = fmt({hi_q, byte_in});
            word_cnt_d = word_cnt_q + WordW'(1);
            phase_d    = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StHunt) || (state_d == StSync1) || (state_d == StSync2) ||
             (state_d == StLoad);
    we_n_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      ce_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      ce_n_q     <= ce_n_d;
      we_n_q     <= we_n_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign icap_ce_n = ce_n_q;
  assign icap_we_n = we_n_q;
  assign icap_din  = din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_icap_loader.sv
// Bench for icap_loader: three parameterisations share one byte stream, checked every cycle.
module tb_icap_loader;

  localparam logic [31:0] Sync = 32'hAA995566;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_stb = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        ce_n [3];
  logic        we_n [3];
  logic        busy [3];
  logic        done [3];
  logic        err  [3];
  logic [15:0] din  [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // k0: plain, limit 8. k1: swapped, limit 4. k2: swapped, default limit.
  int cfg_limit [3] = '{8, 4, 65536};
  bit cfg_swap  [3] = '{1'b0, 1'b1, 1'b1};
  localparam int CfgLen = 2;

  icap_loader #(.SYNC_WORD(Sync), .LEN_WORDS(2), .HUNT_LIMIT(8), .BIT_SWAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_stb(byte_stb), .byte_in(byte_in),
    .icap_ce_n(ce_n[0]), .icap_we_n(we_n[0]), .icap_din(din[0]),
    .busy(busy[0]), .done(done[0]), .error(err[0])
  );
  icap_loader #(.SYNC_WORD(Sync), .LEN_WORDS(2), .HUNT_LIMIT(4), .BIT_SWAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_stb(byte_stb), .byte_in(byte_in),
    .icap_ce_n(ce_n[1]), .icap_we_n(we_n[1]), .icap_din(din[1]),
    .busy(busy[1]), .done(done[1]), .error(err[1])
  );
  icap_loader #(.SYNC_WORD(Sync), .LEN_WORDS(2), .BIT_SWAP(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_stb(byte_stb), .byte_in(byte_in),
    .icap_ce_n(ce_n[2]), .icap_we_n(we_n[2]), .icap_din(din[2]),
    .busy(busy[2]), .done(done[2]), .error(err[2])
  );

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, k, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] tb_fmt(input logic [15:0] w, input bit sw);
    logic [7:0] a, b;
    a = w[15:8];
    b = w[7:0];
    if (sw) begin
      a = {<<{w[15:8]}};
      b = {<<{w[7:0]}};
    end
    return {a, b};
  endfunction

  // ---------------- behavioural model: schedules expected events by cycle ----------------
  typedef struct packed {logic busy; logic done; logic err; logic we_n;} st_t;
  localparam st_t StReset = '{busy: 1'b0, done: 1'b0, err: 1'b0, we_n: 1'b1};

  logic [15:0] wr_exp [int];
  st_t         st_exp [int];
  int          mode   [3];   // 0 idle, 1 hunting, 2 loading, 3 done, 4 failed
  logic [31:0] win    [3];
  int          bcnt   [3];
  int          nw     [3];
  bit          have_hi[3];
  logic [7:0]  hi     [3];

  function automatic int key(input int k, input int c);
    return k * 1000000 + c;
  endfunction

  function automatic st_t mk(input logic b, input logic d, input logic e, input logic w);
    st_t s;
    s.busy = b; s.done = d; s.err = e; s.we_n = w;
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      wr_exp.delete();
      st_exp.delete();
    end
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mode[k] = 0;
        st_exp[key(k, cyc + 1)] = StReset;
      end else if (start && mode[k] != 1 && mode[k] != 2) begin
        mode[k] = 1;
        win[k]  = '0;
        bcnt[k] = 0;
        st_exp[key(k, cyc + 1)] = mk(1'b1, 1'b0, 1'b0, 1'b0);
      end else if (byte_stb && mode[k] == 1) begin
        win[k]  = {win[k][23:0], byte_in};
        bcnt[k] = bcnt[k] + 1;
        if (win[k] == Sync) begin
          mode[k]    = 2;
          nw[k]      = 0;
          have_hi[k] = 1'b0;
          wr_exp[key(k, cyc + 2)] = tb_fmt(Sync[31:16], cfg_swap[k]);
          wr_exp[key(k, cyc + 3)] = tb_fmt(Sync[15:0], cfg_swap[k]);
        end else if (bcnt[k] == cfg_limit[k]) begin
          mode[k] = 4;
          st_exp[key(k, cyc + 1)] = mk(1'b0, 1'b0, 1'b1, 1'b0);
        end
      end else if (byte_stb && mode[k] == 2) begin
        if (!have_hi[k]) begin
          hi[k]      = byte_in;
          have_hi[k] = 1'b1;
        end else begin
          wr_exp[key(k, cyc + 1)] = tb_fmt({hi[k], byte_in}, cfg_swap[k]);
          have_hi[k] = 1'b0;
          nw[k]      = nw[k] + 1;
          if (nw[k] == CfgLen) begin
            mode[k] = 3;
            st_exp[key(k, cyc + 2)] = mk(1'b0, 1'b1, 1'b0, 1'b0);
          end
        end
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- compare process ----------------
  st_t         cur     [3] = '{StReset, StReset, StReset};
  logic [15:0] last_din[3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] log0[$], log1[$], log2[$];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (st_exp.exists(key(k, cyc))) begin
        cur[k] = st_exp[key(k, cyc)];
        if (cur[k] == StReset) last_din[k] = 16'h0000;
      end
      check("busy", k, 32'(busy[k]), 32'(cur[k].busy));
      check("done", k, 32'(done[k]), 32'(cur[k].done));
      check("error", k, 32'(err[k]), 32'(cur[k].err));
      check("we_n", k, 32'(we_n[k]), 32'(cur[k].we_n));
      if (wr_exp.exists(key(k, cyc))) begin
        check("write_ce_n", k, 32'(ce_n[k]), 32'd0);
        check("write_din", k, 32'(din[k]), 32'(wr_exp[key(k, cyc)]));
        last_din[k] = wr_exp[key(k, cyc)];
      end else begin
        check("idle_ce_n", k, 32'(ce_n[k]), 32'd1);
        check("hold_din", k, 32'(din[k]), 32'(last_din[k]));
      end
      if (ce_n[k] === 1'b0) begin
        if (k == 0) log0.push_back(din[k]);
        else if (k == 1) log1.push_back(din[k]);
        else log2.push_back(din[k]);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  function automatic int log_len(input int k);
    return (k == 0) ? log0.size() : (k == 1) ? log1.size() : log2.size();
  endfunction

  function automatic logic [15:0] log_at(input int k, input int i);
    if (i >= log_len(k)) return 16'hxxxx;
    return (k == 0) ? log0[i] : (k == 1) ? log1[i] : log2[i];
  endfunction

  task automatic check_words(input string tag, input int k, input int mark,
                             input logic [63:0] e);
    check({tag, "_count"}, k, 32'(log_len(k) - mark), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check(tag, k, 32'(log_at(k, mark + i)), 32'(e[63-16*i -: 16]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check(tag, k, 32'({ce_n[k], we_n[k], din[k], busy[k], done[k], err[k]}),
            32'({1'b1, 1'b1, 16'h0000, 3'b000}));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); byte_stb = 1'b1; byte_in = b;
    @(negedge clk); byte_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0]  full_stream [10] = '{8'h00, 8'hFF, 8'hAA, 8'h99, 8'h55, 8'h66,
                                   8'h12, 8'h34, 8'h56, 8'h78};
  logic [63:0] plain_words = {16'hAA99, 16'h5566, 16'h1234, 16'h5678};
  logic [63:0] swap_words  = {16'h5599, 16'hAA66, 16'h482C, 16'h6A1E};
  int m0, m1, m2;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    rst_n = 1'b1;
    @(negedge clk);

    // Sync and load: k0 plain, k2 bit-swapped; k1 times out after 4 bytes.
    m0 = log_len(0); m2 = log_len(2);
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(full_stream[i]);
    repeat (3) @(negedge clk);
    check_words("plain_words", 0, m0, plain_words);
    check_words("swap_words", 2, m2, swap_words);
    check("done_set", 0, 32'({done[0], busy[0]}), 32'b10);
    check("done_set", 2, 32'({done[2], busy[2]}), 32'b10);
    check("limit4_fail", 1, 32'({err[1], busy[1]}), 32'b10);

    // Match on the limit byte, with a start pulse ignored mid-load.
    m0 = log_len(0); m1 = log_len(1);
    pulse_start();
    for (int i = 2; i < 8; i++) send_byte(full_stream[i]);
    pulse_start();
    for (int i = 8; i < 10; i++) send_byte(full_stream[i]);
    repeat (3) @(negedge clk);
    check_words("limit_match_words", 1, m1, swap_words);
    check_words("start_ignored_words", 0, m0, plain_words);
    check("limit_match_no_err", 1, 32'({done[1], err[1]}), 32'b10);

    // Hunt timeout on k0 after eight FF bytes.
    m0 = log_len(0);
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(8'hFF);
    @(negedge clk); byte_stb = 1'b1; byte_in = 8'hFF;
    check("err_before_limit", 0, 32'(err[0]), 32'd0);
    @(negedge clk); byte_stb = 1'b0;
    check("err_after_limit", 0, 32'({err[0], busy[0]}), 32'b10);
    repeat (3) @(negedge clk);
    check("timeout_no_write", 0, 32'(log_len(0) - m0), 32'd0);

    // Reset mid-load, then a full run.
    m0 = log_len(0);
    pulse_start();
    for (int i = 2; i < 8; i++) send_byte(full_stream[i]);
    check("pre_reset_writes", 0, 32'(log_len(0) - m0), 32'd3);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m0 = log_len(0); m2 = log_len(2);
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(full_stream[i]);
    repeat (3) @(negedge clk);
    check_words("post_reset_words", 0, m0, plain_words);
    check_words("post_reset_words", 2, m2, swap_words);
    check("post_reset_done", 0, 32'({done[0], busy[0], err[0]}), 32'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
